fft32_r4_sequencer: RTL and testbench

Control and address generator for the 32-point mixed-radix (4x4x2) DIF FFT built around the shared radix-4 butterfly and an in-place 32-entry sample memory. It sequences four phases per frame: LOAD (32 input samples), three COMPUTE stages that issue butterfly operand addresses and twiddle exponents, and UNLOAD (results in natural frequency order). The block does no arithmetic. It drives the memory, butterfly and twiddle ROM control, and sits between the sample source and the FFT datapath.

---
 rtl/fft32_pkg.sv | 40 ++++
 rtl/fft32_addr_gen.sv | 66 ++++++
 rtl/fft32_r4_sequencer.sv | 156 +++++++++++++++
 tb/tb_fft32_r4_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft32_pkg.sv
// Shared definitions for the 32-point 4x4x2 DIF FFT sequencer.
// Holds the frame length, address width, the phase encoding, per-stage
// butterfly counts and the digit-reversal used to unload in natural order.
package fft32_pkg;

  localparam int N_PTS  = 32;
  localparam int ADDR_W = 5;
  // Wide enough to count 0..32 (unload reaches 32 after the last read).
  localparam int CNT_W  = 6;

  localparam int C0_OPS = 8;
  localparam int C1_OPS = 8;
  localparam int C2_OPS = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    C0     = 3'd2,
    C1     = 3'd3,
    C2     = 3'd4,
    UNLOAD = 3'd5
  } state_t;

  // Memory location of frequency bin k after the in-place 4x4x2 DIF:
  // (k%4)*8 + ((k/4)%4)*2 + k/16.
  function automatic logic [ADDR_W-1:0] digit_rev(input logic [ADDR_W-1:0] k);
    return {k[1:0], k[3:2], k[4]};
  endfunction

  // Number of butterflies issued in a compute stage (0 outside compute).
  function automatic logic [CNT_W-1:0] stage_ops(input state_t st);
    case (st)
      C0:      return CNT_W'(C0_OPS);
      C1:      return CNT_W'(C1_OPS);
      C2:      return CNT_W'(C2_OPS);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/fft32_addr_gen.sv
// Combinational operand-address and twiddle-exponent generator.
// Ports:
//   stage     - current compute phase (C0/C1/C2; anything else yields zeros)
//   op        - butterfly index within the stage
//   bf_addr   - {a3,a2,a1,a0} operand addresses, 5 bits each
//   tw_exp    - {e3,e2,e1,e0} exponents of W32, 5 bits each
//   bf_radix2 - high for the final radix-2 stage (a2/a3/e* are zero)
module fft32_addr_gen
  import fft32_pkg::*;
(
  input  state_t      stage,
  input  logic [3:0]  op,
  output logic [19:0] bf_addr,
  output logic [19:0] tw_exp,
  output logic        bf_radix2
);

  logic [2:0]        o;
  logic [ADDR_W-1:0] c1_base;
  logic [ADDR_W-1:0] c0_addr [4];
  logic [ADDR_W-1:0] c0_exp  [4];
  logic [ADDR_W-1:0] c1_addr [4];
  logic [ADDR_W-1:0] c1_exp  [4];

  assign o       = op[2:0];
  // C1 works on groups of 8 points; pairs of ops share a group.
  assign c1_base = {o[2:1], 3'b000};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      // Stage 0: stride-8 groups, twiddle k*g (5-bit product wraps mod 32).
      assign c0_addr[gi] = ADDR_W'(gi * 8) + {2'b00, o};
      assign c0_exp[gi]  = ADDR_W'(gi) * {2'b00, o};
      // Stage 1: stride-2 inside each 8-point group, twiddle 4*k*j.
      assign c1_addr[gi] = c1_base + {4'b0000, o[0]} + ADDR_W'(gi * 2);
      assign c1_exp[gi]  = o[0] ? ADDR_W'(gi * 4) : '0;
    end
  endgenerate

  always_comb begin
    bf_addr   = '0;
    tw_exp    = '0;
    bf_radix2 = 1'b0;
    case (stage)
      C0: begin
        for (int k = 0; k < 4; k++) begin
          bf_addr[k*ADDR_W +: ADDR_W] = c0_addr[k];
          tw_exp[k*ADDR_W +: ADDR_W]  = c0_exp[k];
        end
      end
      C1: begin
        for (int k = 0; k < 4; k++) begin
          bf_addr[k*ADDR_W +: ADDR_W] = c1_addr[k];
          tw_exp[k*ADDR_W +: ADDR_W]  = c1_exp[k];
        end
      end
      C2: begin
        bf_addr[4:0] = {op, 1'b0};
        bf_addr[9:5] = {op, 1'b1};
        bf_radix2    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fft32_r4_sequencer.sv
// Frame sequencer for the 32-point mixed-radix FFT: LOAD 32 samples,
// three compute stages of butterfly issues, then UNLOAD in bin order.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   in_valid/in_ready, wr_en/wr_addr - sample load handshake and memory write
//   bf_valid/bf_ready, bf_addr, bf_radix2, tw_exp - butterfly issue
//   wb_valid                        - one outstanding butterfly written back
//   out_ready, rd_en/rd_addr        - unload read request
//   out_valid, out_index, out_last  - read data qualifier (1-cycle latency)
//   busy, frame_done                - status
module fft32_r4_sequencer
  import fft32_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic        bf_valid,
  input  logic        bf_ready,
  output logic [19:0] bf_addr,
  output logic        bf_radix2,
  output logic [19:0] tw_exp,
  input  logic        wb_valid,
  input  logic        out_ready,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        frame_done
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // sample / op / bin counter of the phase
  logic [2:0]        outst_q, outst_d;  // issued but not written back
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;

  logic              compute, accept, issue, wb_take, stage_done;
  logic [CNT_W-1:0]  ops;
  logic [19:0]       gen_addr, gen_exp;
  logic              gen_r2;

  fft32_addr_gen u_addr_gen (
    .stage     (state_q),
    .op        (cnt_q[3:0]),
    .bf_addr   (gen_addr),
    .tw_exp    (gen_exp),
    .bf_radix2 (gen_r2)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      outst_q      <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      outst_q      <= outst_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output logic
  always_comb begin
    compute    = (state_q == C0) || (state_q == C1) || (state_q == C2);
    ops        = stage_ops(state_q);
    in_ready   = (state_q == IDLE) || (state_q == LOAD);
    accept     = in_ready && in_valid;
    wr_en      = accept;
    wr_addr    = accept ? cnt_q[4:0] : '0;
    bf_valid   = compute && (cnt_q < ops) && (outst_q < 3'(MAX_OUTSTANDING));
    issue      = bf_valid && bf_ready;
    // A writeback with nothing outstanding is spurious and dropped.
    wb_take    = wb_valid && (outst_q != 3'd0);
    // In-place memory: the next stage reads what this one writes, so wait
    // for every writeback before moving on.
    stage_done = compute && (cnt_q == ops) && (outst_q == 3'd0);
    bf_addr    = bf_valid ? gen_addr : '0;
    tw_exp     = bf_valid ? gen_exp : '0;
    bf_radix2  = bf_valid && gen_r2;
    rd_en      = (state_q == UNLOAD) && (cnt_q < CNT_W'(N_PTS)) && out_ready;
    rd_addr    = rd_en ? digit_rev(cnt_q[4:0]) : '0;
    out_valid  = out_valid_q;
    out_index  = out_index_q;
    out_last   = out_last_q;
    busy       = (state_q != IDLE);
    frame_done = frame_done_q;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    outst_d      = outst_q + {2'b00, issue} - {2'b00, wb_take};
    out_valid_d  = rd_en;
    out_index_d  = rd_en ? cnt_q[4:0] : '0;
    out_last_d   = rd_en && (cnt_q == CNT_W'(N_PTS - 1));
    frame_done_d = out_valid_q && out_last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(1);
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt_q == CNT_W'(N_PTS - 1)) begin
            state_d = C0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      C0, C1, C2: begin
        if (stage_done) begin
          state_d = (state_q == C0) ? C1 : (state_q == C1) ? C2 : UNLOAD;
          cnt_d   = '0;
        end else if (issue) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UNLOAD: begin
        if (out_valid_q && out_last_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rd_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fft32_r4_sequencer.sv
module tb_fft32_r4_sequencer;

  logic        clk, rst_n, in_valid, in_ready, wr_en;
  logic [4:0]  wr_addr;
  logic        bf_valid, bf_ready, bf_radix2, wb_valid, out_ready, rd_en;
  logic [19:0] bf_addr, tw_exp;
  logic [4:0]  rd_addr, out_index;
  logic        out_valid, out_last, busy, frame_done;

  fft32_r4_sequencer #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .bf_valid(bf_valid), .bf_ready(bf_ready),
    .bf_addr(bf_addr), .bf_radix2(bf_radix2), .tw_exp(tw_exp), .wb_valid(wb_valid),
    .out_ready(out_ready), .rd_en(rd_en), .rd_addr(rd_addr), .out_valid(out_valid),
    .out_index(out_index), .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [19:0] addr;
    logic [19:0] tw;
    logic        r2;
  } iss_t;

  iss_t exp_iss[$];
  int   exp_wr[$];
  int   exp_rd[$];
  int   exp_k[$];
  int   hand_rd[6] = '{0, 8, 16, 24, 2, 10};

  int checks = 0;
  int errors = 0;
  int load_cnt, iss_cnt, rd_cnt, model_out;
  int frames_done = 0;
  int lasts_seen = 0;
  bit prev_last, last_iss;
  int wb_mode;       // 0: echo 3 cycles after issue, 1: manual, 2: drain every cycle
  bit wb_man;
  bit ready_toggle;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic extra(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, got 1 expected 0", name);
  endtask

  function automatic logic [19:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic clear_model();
    exp_iss.delete();
    exp_wr.delete();
    exp_rd.delete();
    exp_k.delete();
    load_cnt  = 0;
    iss_cnt   = 0;
    rd_cnt    = 0;
    model_out = 0;
    prev_last = 1'b0;
    last_iss  = 1'b0;
  endtask

  // Expected transactions of one frame, straight from the FFT index maths.
  task automatic push_frame();
    iss_t e;
    for (int i = 0; i < 32; i++) exp_wr.push_back(i);
    for (int g = 0; g < 8; g++) begin
      e.addr = pk(g + 24, g + 16, g + 8, g);
      e.tw   = pk((3 * g) % 32, (2 * g) % 32, g, 0);
      e.r2   = 1'b0;
      exp_iss.push_back(e);
    end
    for (int o = 0; o < 8; o++) begin
      int base, j;
      base   = (o / 2) * 8;
      j      = o % 2;
      e.addr = pk(base + j + 6, base + j + 4, base + j + 2, base + j);
      e.tw   = pk((12 * j) % 32, (8 * j) % 32, (4 * j) % 32, 0);
      e.r2   = 1'b0;
      exp_iss.push_back(e);
    end
    for (int m = 0; m < 16; m++) begin
      e.addr = pk(0, 0, 2 * m + 1, 2 * m);
      e.tw   = '0;
      e.r2   = 1'b1;
      exp_iss.push_back(e);
    end
    for (int k = 0; k < 32; k++) begin
      exp_rd.push_back((k % 4) * 8 + ((k / 4) % 4) * 2 + k / 16);
      exp_k.push_back(k);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    iss_t e;
    int   kk;
    bit   iss, wbt;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_done || prev_last) chk("frame_done_timing", frame_done, prev_last);
        if (frame_done) begin
          chk("frame_issues", iss_cnt, 32);
          chk("frame_reads", rd_cnt, 32);
          frames_done++;
          $display("frame %0d done", frames_done);
          load_cnt = 0;
          iss_cnt  = 0;
          rd_cnt   = 0;
        end
        prev_last = out_valid && out_last;
        chk("in_ready", int'(in_ready), int'(load_cnt < 32));

        if (wr_en) begin
          if (exp_wr.size() == 0) extra("wr_extra");
          else chk("wr_addr", wr_addr, exp_wr.pop_front());
          load_cnt++;
        end

        iss = bf_valid && bf_ready;
        if (iss) begin
          $display("issue %0d addr %05h tw %05h r2 %0d", iss_cnt, bf_addr, tw_exp, bf_radix2);
          if (iss_cnt == 8 || iss_cnt == 16) chk("stage_drain", model_out, 0);
          if (iss_cnt == 3) begin
            chk("c0_g3_addr", bf_addr, pk(27, 19, 11, 3));
            chk("c0_g3_tw", tw_exp, pk(9, 6, 3, 0));
          end
          if (iss_cnt == 13) begin
            chk("c1_o5_addr", bf_addr, pk(23, 21, 19, 17));
            chk("c1_o5_tw", tw_exp, pk(12, 8, 4, 0));
          end
          if (iss_cnt == 23) begin
            chk("c2_m7_addr", bf_addr, pk(0, 0, 15, 14));
            chk("c2_m7_r2", bf_radix2, 1);
          end
          if (exp_iss.size() == 0) extra("issue_extra");
          else begin
            e = exp_iss.pop_front();
            chk("bf_addr", bf_addr, e.addr);
            chk("tw_exp", tw_exp, e.tw);
            chk("bf_radix2", bf_radix2, e.r2);
          end
          iss_cnt++;
        end

        if (rd_en) begin
          $display("read k=%0d addr %0d", rd_cnt, rd_addr);
          chk("rd_on_ready", out_ready, 1);
          if (rd_cnt == 0) chk("unload_drain", model_out, 0);
          if (rd_cnt < 6) chk("rd_hand", rd_addr, hand_rd[rd_cnt]);
          if (exp_rd.size() == 0) extra("rd_extra");
          else chk("rd_addr", rd_addr, exp_rd.pop_front());
          rd_cnt++;
        end

        if (out_valid) begin
          if (out_last) lasts_seen++;
          if (exp_k.size() == 0) extra("out_extra");
          else begin
            kk = exp_k.pop_front();
            chk("out_index", out_index, kk);
            chk("out_last", out_last, int'(kk == 31));
          end
        end

        wbt = wb_valid && (model_out > 0);
        if (wb_valid && model_out == 0) extra("wb_underflow");
        model_out = model_out + int'(iss) - int'(wbt);
        last_iss  = iss;
      end else begin
        last_iss = 1'b0;
      end
    end
  end

  // Writeback and out_ready driver
  initial begin
    bit [2:0] pipe;
    pipe = '0;
    forever begin
      @(posedge clk);
      #2;
      pipe = {pipe[1:0], last_iss};
      if (wb_mode == 0) begin
        wb_valid = pipe[2];
      end else if (wb_mode == 1) begin
        pipe     = '0;
        wb_valid = wb_man;
      end else begin
        pipe     = '0;
        wb_valid = (model_out > 0);
      end
      if (ready_toggle) out_ready = ~out_ready;
      else out_ready = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0: return load_cnt;
      1: return iss_cnt;
      2: return frames_done;
      default: return lasts_seen;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int target);
    int n;
    n = 0;
    while (get_cnt(which) < target && n < 2000) begin
      step();
      n++;
    end
    if (get_cnt(which) < target) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d expected %0d", name, get_cnt(which), target);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    bf_ready     = 1'b0;
    wb_valid     = 1'b0;
    out_ready    = 1'b0;
    wb_mode      = 1;
    wb_man       = 1'b0;
    ready_toggle = 1'b0;
    clear_model();
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bf_valid", bf_valid, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);

    // Frame 1: in_valid held through the whole frame, echo writeback, toggling out_ready
    push_frame();
    bf_ready     = 1'b1;
    wb_mode      = 0;
    ready_toggle = 1'b1;
    in_valid     = 1'b1;
    wait_for("f1_last", 3, 1);
    in_valid = 1'b0;
    wait_for("f1_done", 2, 1);
    ready_toggle = 1'b0;

    // Frame 2: writeback withheld, outstanding limit and simultaneous issue+wb
    push_frame();
    wb_mode  = 1;
    wb_man   = 1'b0;
    in_valid = 1'b1;
    wait_for("f2_load", 0, 32);
    in_valid = 1'b0;
    wait_for("f2_iss4", 1, 4);
    repeat (3) step();
    chk("limit_bf_valid", bf_valid, 0);
    chk("limit_issues", iss_cnt, 4);
    wb_man = 1'b1;
    step();
    step();
    wb_man = 1'b0;
    repeat (4) step();
    chk("simul_issues", iss_cnt, 6);
    chk("simul_bf_valid", bf_valid, 0);
    wb_mode = 2;
    wait_for("f2_done", 2, 2);

    // Frame 3: abandoned by a one-cycle reset in the middle of C1
    push_frame();
    wb_mode  = 0;
    in_valid = 1'b1;
    wait_for("f3_load", 0, 32);
    in_valid = 1'b0;
    wait_for("f3_c1", 1, 10);
    bf_ready = 1'b0;
    wb_mode  = 1;
    wb_man   = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_model();
    chk("midrst_busy", busy, 0);
    chk("midrst_bf_valid", bf_valid, 0);
    chk("midrst_in_ready", in_ready, 1);

    // Frame 4: fresh frame after the reset
    push_frame();
    wb_mode  = 0;
    bf_ready = 1'b1;
    in_valid = 1'b1;
    wait_for("f4_load", 0, 32);
    in_valid = 1'b0;
    wait_for("f4_done", 2, 3);

    repeat (5) step();
    chk("frames_done", frames_done, 3);
    chk("end_busy", busy, 0);
    chk("left_iss", exp_iss.size(), 0);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_out", exp_k.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
